spine_leaf_injector: RTL and testbench

Leaf-side transmitter that builds packets and injects them into one leaf port of a spine router (spineNx_in_data/valid). It takes a request (destination, length) and a payload stream from local logic. It emits a header flit followed by payload flits on the router's valid/data link, which has no ready signal. Flow control is credit-based: CREDITS equals the router input FIFO depth, and the router returns one credit per flit it drains.

---
 rtl/spine_leaf_injector.sv | 154 +++++++++++++++
 tb/tb_spine_leaf_injector.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spine_leaf_injector.sv
// Purpose : leaf-side packet builder; emits a header flit then len payload flits into a spine router leaf port.
// Latency : a flit sent in cycle N is visible on spine_out_valid/data in cycle N+1 (registered outputs).
// Backpressure: credit-based; no send while credits==0, pl_ready stalls the payload source.
//
// Ports:
//   clk, reset (async active-low)
//   req_valid/req_ready/req_dest/req_len   : packet request handshake
//   pl_valid/pl_ready/pl_data              : payload stream handshake
//   spine_out_valid/spine_out_data         : flit link to the router (no ready)
//   credit_return                          : one pulse per router FIFO slot freed
//   credits, busy, credit_err              : status (credit_err is sticky until reset)
module spine_leaf_injector #(
  parameter int          DWIDTH    = 16,
  parameter logic [3:0]  SRC_GROUP = 4'b0111,
  parameter int          SRC_ID    = 2,
  parameter int          CREDITS   = 8,
  parameter int          CW        = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_dest,
  input  logic [3:0]        req_len,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic [DWIDTH-1:0] pl_data,
  output logic [DWIDTH-1:0] spine_out_data,
  output logic              spine_out_valid,
  input  logic              credit_return,
  output logic [CW-1:0]     credits,
  output logic              busy,
  output logic              credit_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } state_e;

  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [1:0]    SRC_LO   = SRC_ID[1:0];

  state_e            state_q, state_d;
  logic [5:0]        dest_q, dest_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [CW-1:0]     credits_q, credits_d;
  logic              err_q, err_d;
  logic              out_vld_q;
  logic [DWIDTH-1:0] out_dat_q;

  logic              send;
  logic [DWIDTH-1:0] send_dat;
  logic              credit_ok;
  logic [DWIDTH-1:0] hdr_flit;
  logic [3:0]        cnt_inc;

  // Send decisions look only at the registered count, so a credit
  // returned while at zero becomes usable one cycle later.
  assign credit_ok = (credits_q != '0);
  assign hdr_flit  = {dest_q, SRC_GROUP, SRC_LO, len_q};
  assign cnt_inc   = cnt_q + 4'd1;

  // Next-state, handshakes and flit selection.
  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    send      = 1'b0;
    send_dat  = '0;
    req_ready = 1'b0;
    pl_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          dest_d  = req_dest;
          len_d   = req_len;
          state_d = HDR;
        end
      end
      HDR: begin
        if (credit_ok) begin
          send     = 1'b1;
          send_dat = hdr_flit;
          cnt_d    = '0;
          state_d  = (len_q != 4'd0) ? PAYLOAD : IDLE;
        end
      end
      PAYLOAD: begin
        pl_ready = credit_ok;
        if (pl_valid && credit_ok) begin
          send     = 1'b1;
          send_dat = pl_data;
          cnt_d    = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit counter. A return while already full is dropped and flagged;
  // a send only happens with credits>0, so there is no underflow path.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    case ({credit_return, send})
      2'b10: begin
        if (credits_q == CRED_MAX) begin
          err_d = 1'b1;
        end else begin
          credits_d = credits_q + CW'(1);
        end
      end
      2'b01:   credits_d = credits_q - CW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      dest_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      credits_q <= CRED_MAX;
      err_q     <= 1'b0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      credits_q <= credits_d;
      err_q     <= err_d;
      out_vld_q <= send;
      out_dat_q <= send ? send_dat : '0;
    end
  end

  assign spine_out_valid = out_vld_q;
  assign spine_out_data  = out_dat_q;
  assign credits         = credits_q;
  assign credit_err      = err_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_spine_leaf_injector.sv
module tb_spine_leaf_injector;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_dest;
  logic [3:0]  req_len;
  logic        pl_valid;
  logic        pl_ready;
  logic [15:0] pl_data;
  logic [15:0] spine_out_data;
  logic        spine_out_valid;
  logic        credit_return;
  logic [3:0]  credits;
  logic        busy;
  logic        credit_err;

  int n_cmp = 0;
  int n_err = 0;

  spine_leaf_injector #(
    .DWIDTH(16), .SRC_GROUP(4'b0111), .SRC_ID(2), .CREDITS(8), .CW(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .req_len(req_len),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
    .spine_out_data(spine_out_data), .spine_out_valid(spine_out_valid),
    .credit_return(credit_return), .credits(credits),
    .busy(busy), .credit_err(credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1ns past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("mismatch on %s", tag);
    end
  endtask

  // Reset pulse applied away from the clock edge.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    #3;
    reset = 1'b1;
    tick();
  endtask

  int flits;
  int pidx;
  logic took;

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_dest = '0; req_len = '0;
    pl_valid = 1'b0; pl_data = '0; credit_return = 1'b0;
    #12;
    // reset state
    chk("rst_valid", 32'(spine_out_valid), 32'd0);
    chk("rst_data", 32'(spine_out_data), 32'd0);
    chk("rst_credits", 32'(credits), 32'd8);
    chk("rst_err", 32'(credit_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_pl_ready", 32'(pl_ready), 32'd0);
    reset = 1'b1;
    tick();

    // 1: basic packet len 3
    req_valid = 1'b1; req_dest = 6'b0101_10; req_len = 4'd3;
    tick();
    req_valid = 1'b0;
    chk("t1_busy_hdr", 32'(busy), 32'd1);
    chk("t1_no_flit_on_accept", 32'(spine_out_valid), 32'd0);
    chk("t1_req_ready_hdr", 32'(req_ready), 32'd0);
    pl_valid = 1'b1; pl_data = 16'hA001;
    tick();
    chk("t1_hdr_vld", 32'(spine_out_valid), 32'd1);
    chk("t1_hdr_dat", 32'(spine_out_data), 32'h59E3);
    chk("t1_cred7", 32'(credits), 32'd7);
    chk("t1_pl_ready", 32'(pl_ready), 32'd1);
    tick();
    chk("t1_p1", 32'(spine_out_data), 32'hA001);
    pl_data = 16'hA002;
    tick();
    chk("t1_p2", 32'(spine_out_data), 32'hA002);
    pl_data = 16'hA003;
    tick();
    chk("t1_p3_vld", 32'(spine_out_valid), 32'd1);
    chk("t1_p3", 32'(spine_out_data), 32'hA003);
    chk("t1_cred4", 32'(credits), 32'd4);
    chk("t1_busy_done", 32'(busy), 32'd0);
    pl_valid = 1'b0;
    tick();
    chk("t1_idle_vld", 32'(spine_out_valid), 32'd0);
    chk("t1_idle_dat", 32'(spine_out_data), 32'd0);

    // 2: header-only packet
    do_reset();
    req_valid = 1'b1; req_dest = 6'h3F; req_len = 4'd0;
    tick();
    req_valid = 1'b0;
    chk("t2_pl_ready_hdr", 32'(pl_ready), 32'd0);
    tick();
    chk("t2_hdr_vld", 32'(spine_out_valid), 32'd1);
    chk("t2_hdr_dat", 32'(spine_out_data), 32'hFDE0);
    chk("t2_cred7", 32'(credits), 32'd7);
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_pl_ready_idle", 32'(pl_ready), 32'd0);
    tick();
    chk("t2_single_flit", 32'(spine_out_valid), 32'd0);

    // 3: credit exhaustion
    do_reset();
    req_valid = 1'b1; req_dest = 6'h12; req_len = 4'd10;
    tick();
    req_valid = 1'b0;
    pidx = 0; flits = 0;
    pl_valid = 1'b1; pl_data = 16'hD001;
    for (int c = 0; c < 14; c++) begin
      took = pl_ready;
      tick();
      if (spine_out_valid) begin
        if (flits == 0) chk("t3_hdr", 32'(spine_out_data), 32'h49EA);
        else chk("t3_payload", 32'(spine_out_data), 32'(16'hD001 + 16'(flits - 1)));
        flits++;
      end
      if (took) pidx++;
      pl_data = 16'hD001 + 16'(pidx);
    end
    chk("t3_flits8", 32'(flits), 32'd8);
    chk("t3_pl_ready0", 32'(pl_ready), 32'd0);
    chk("t3_cred0", 32'(credits), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    for (int r = 0; r < 3; r++) begin
      credit_return = 1'b1;
      tick();
      credit_return = 1'b0;
      chk("t3_ret_no_flit", 32'(spine_out_valid), 32'd0);
      chk("t3_ret_cred1", 32'(credits), 32'd1);
      chk("t3_ret_pl_ready", 32'(pl_ready), 32'd1);
      tick();
      chk("t3_ret_flit_vld", 32'(spine_out_valid), 32'd1);
      chk("t3_ret_flit_dat", 32'(spine_out_data), 32'(16'hD008 + 16'(r)));
      chk("t3_ret_cred0", 32'(credits), 32'd0);
      pl_data = 16'hD009 + 16'(r);
    end
    chk("t3_done", 32'(busy), 32'd0);
    pl_valid = 1'b0;
    tick();
    chk("t3_no_extra", 32'(spine_out_valid), 32'd0);

    // 4: simultaneous return and send
    do_reset();
    req_valid = 1'b1; req_dest = 6'h05; req_len = 4'd8;
    tick();
    req_valid = 1'b0;
    pl_valid = 1'b1; pl_data = 16'hE001;
    tick();
    chk("t4_hdr", 32'(spine_out_data), 32'h15E8);
    tick();
    pl_data = 16'hE002;
    tick();
    chk("t4_cred5", 32'(credits), 32'd5);
    pl_data = 16'hE003;
    credit_return = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t4_vld", 32'(spine_out_valid), 32'd1);
      chk("t4_dat", 32'(spine_out_data), 32'(16'hE003 + 16'(k)));
      chk("t4_cred", 32'(credits), 32'd5);
      pl_data = 16'hE004 + 16'(k);
    end
    credit_return = 1'b0;
    pl_valid = 1'b0;
    chk("t4_done", 32'(busy), 32'd0);

    // 5: credit overflow
    do_reset();
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    chk("t5_cred8", 32'(credits), 32'd8);
    chk("t5_err", 32'(credit_err), 32'd1);
    tick();
    tick();
    chk("t5_err_sticky", 32'(credit_err), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_err_async_clr", 32'(credit_err), 32'd0);
    #1;
    reset = 1'b1;
    tick();

    // 6: reset mid-packet
    req_valid = 1'b1; req_dest = 6'h2A; req_len = 4'd5;
    tick();
    req_valid = 1'b0;
    pl_valid = 1'b1; pl_data = 16'hB001;
    tick();
    tick();
    pl_data = 16'hB002;
    tick();
    chk("t6_p2", 32'(spine_out_data), 32'hB002);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_vld", 32'(spine_out_valid), 32'd0);
    chk("t6_async_dat", 32'(spine_out_data), 32'd0);
    pl_valid = 1'b0;
    #1;
    reset = 1'b1;
    tick();
    chk("t6_cred8", 32'(credits), 32'd8);
    chk("t6_req_ready", 32'(req_ready), 32'd1);
    chk("t6_no_stale", 32'(spine_out_valid), 32'd0);
    req_valid = 1'b1; req_dest = 6'h21; req_len = 4'd1;
    tick();
    req_valid = 1'b0;
    pl_valid = 1'b1; pl_data = 16'h1234;
    tick();
    chk("t6_hdr", 32'(spine_out_data), 32'h85E1);
    tick();
    chk("t6_pl", 32'(spine_out_data), 32'h1234);
    chk("t6_done", 32'(busy), 32'd0);
    pl_valid = 1'b0;
    tick();
    chk("t6_end_vld", 32'(spine_out_valid), 32'd0);
    chk("t6_end_cred", 32'(credits), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
